mips_debug_unit: RTL
====================

# mips_debug_unit

Parametrised UART-side debug controller for the MIPS pipeline: decodes command bytes from the UART receiver, loads program memory, runs or single-steps the core, and streams a snapshot of an arbitrary-width debug bus back to the UART transmitter byte by byte. It sits between the UART rx/tx pair and the MIPS core in the top level, replacing the fixed-width debugger. Debug-bus width, instruction width and program-address width are parameters. Beyond the fixed-width design it adds count-framed loading, run-to-stop mode and snapshot-consistent dumps.

## Interface
- DBG_W, default 2558: width of debug bus from the core; padded with zeros to NBYTES = ceil(DBG_W/8).
- INSTR_BYTES, default 4: bytes per instruction word; INSTR_W = 8*INSTR_BYTES.
- ADDR_W, default 8: program-memory address width.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- i_rx_done  in  1  one-cycle pulse; i_data valid in the same cycle.
- i_data  in  8  received byte.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- i_stop  in  1  core halted, i.e. HALT reached the end of the pipeline; level.
- i_dbg_data  in  DBG_W  core state bus.
- o_step  out  1  core clock-enable.
- o_mem_write  out  1  one-cycle program-memory write strobe.
- o_instruction  out  INSTR_W  write data.
- o_address  out  ADDR_W  write address.
- o_data_send  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- o_busy  out  1  high in every state except IDLE.

## Operation
- Commands are accepted only in IDLE:
  - 0x01 LOAD
  - 0x02 RUN
  - 0x03 STEP
  - 0x04 DUMP
  - any other byte is ignored and the FSM stays in IDLE.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SNAP, TX_SEND, TX_WAIT.
- LOAD:
  - Next rx byte is the count C, in LOAD_CNT.
  - C=0 returns to IDLE with no writes.
  - Otherwise collect C*INSTR_BYTES bytes, MSB first, into the word.
  - After each complete word, LOAD_WR drives o_mem_write for 1 cycle, then increments the address.
  - The address starts at 0 on each LOAD and wraps modulo 2^ADDR_W.
  - After the C-th write, go to IDLE.
- RUN:
  - o_step is held high each cycle while i_stop is low.
  - On the first cycle i_stop is high, o_step drops and the FSM goes to SNAP.
  - If i_stop is already high on entry, no step is issued.
- STEP:
  - o_step pulses for exactly 1 cycle, suppressed if i_stop is high.
  - Then SNAP.
- DUMP: go directly to SNAP.
- SNAP:
  - Capture i_dbg_data into a zero-padded NBYTES*8 shadow register.
  - Byte index = 0.
- TX_SEND:
  - o_data_send = shadow byte[index], least-significant byte first.
  - o_tx_start = 1 for 1 cycle.
  - Then TX_WAIT.
- TX_WAIT:
  - On i_tx_done, index+1.
  - If index was NBYTES-1, go to IDLE; otherwise TX_SEND.
- i_rx_done outside IDLE/LOAD_CNT/LOAD_BYTE is ignored; the byte is dropped.

## Timing
- Reset values: all outputs 0; state IDLE; address 0; shadow 0.
- A command byte changes state the cycle after its i_rx_done.
- o_mem_write asserts the cycle after the i_rx_done of a word's last byte. o_address and o_instruction are stable during that cycle.
- The snapshot is taken 1 cycle after o_step falls (STEP/RUN), or 1 cycle after the DUMP command.
- o_data_send is held constant from TX_SEND until the matching i_tx_done.
- Minimum one idle cycle between consecutive o_tx_start pulses.
- i_tx_done arriving in TX_SEND (before the start pulse) is ignored.
- i_tx_done and rst in the same cycle: rst wins.
- Reset in any state aborts the operation: partial words are discarded and no further strobes are issued.

## Structure
- Package mips_debug_pkg: command opcodes, state enum, function nbytes(DBG_W).
- Sub-module dbg_byte_serializer: holds the shadow register, byte index and tx handshake. Parameters NBYTES; ports start, done_all. The parent FSM keeps the command/load/run logic.

## Test plan
- Reset then LOAD: bytes 0x01, 0x02, then 0x11 0x22 0x33 0x44 0xAA 0xBB 0xCC 0xDD -> two o_mem_write pulses: addr 0 data 0x11223344, then addr 1 data 0xAABBCCDD; then IDLE.
- LOAD with C=0 -> no o_mem_write, o_busy low 1 cycle after the count byte.
- STEP with DBG_W=2558 and a known bus pattern -> exactly one o_step cycle, then 320 tx bytes LSB first; the top byte's 2 MSBs are 0. Responds to a tx_done delay of 10 cycles per byte.
- RUN with i_stop raised after 37 cycles -> exactly 37 o_step cycles, then a full dump. The bus changing during the dump does not alter the transmitted bytes.
- Unknown byte 0x7F, and a byte received mid-dump -> ignored; dump byte count is unchanged.
- rst asserted during TX_WAIT of byte 5 -> outputs 0 next cycle; a following DUMP restarts from byte 0.

Source files
------------

// File: rtl/mips_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_debug_pkg
// Purpose  : Shared definitions for the UART-side MIPS debug controller:
//            command opcodes, controller state encoding and the helper that
//            sizes the byte-padded debug snapshot.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_debug_pkg;

    localparam logic [7:0] c_CMD_LOAD = 8'h01;
    localparam logic [7:0] c_CMD_RUN  = 8'h02;
    localparam logic [7:0] c_CMD_STEP = 8'h03;
    localparam logic [7:0] c_CMD_DUMP = 8'h04;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_CNT  = 4'd1,
        ST_LOAD_BYTE = 4'd2,
        ST_LOAD_WR   = 4'd3,
        ST_RUN       = 4'd4,
        ST_STEP      = 4'd5,
        ST_SNAP      = 4'd6,
        ST_TX_SEND   = 4'd7,
        ST_TX_WAIT   = 4'd8
    } dbg_state_t;

    // Number of whole bytes needed to carry a dbg_w-bit bus.
    function automatic int nbytes(input int dbg_w);
        return (dbg_w + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dbg_byte_serializer
// Purpose  : Holds a zero-padded snapshot of the debug bus and hands it to the
//            UART transmitter one byte at a time, least-significant first.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_start         - capture i_dbg_data, rewind to byte 0
//            i_send          - parent is in its send phase (raise tx start)
//            i_wait          - parent is waiting for the transmitter
//            i_tx_done       - transmitter finished the current byte
//            i_dbg_data      - live core state bus
//            o_data_send     - byte currently selected for transmission
//            o_tx_start      - transmit request
//            o_done_all      - last byte acknowledged by the transmitter
// Revision : 1.0 - initial release
// ============================================================================
module dbg_byte_serializer #(
    parameter int DBG_W  = 2558,
    parameter int NBYTES = 320
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_send,
    input  logic             i_wait,
    input  logic             i_tx_done,
    input  logic [DBG_W-1:0] i_dbg_data,
    output logic [7:0]       o_data_send,
    output logic             o_tx_start,
    output logic             o_done_all
);

    localparam int c_SH_W  = NBYTES * 8;
    localparam int c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NBYTES - 1);

    logic [c_SH_W-1:0]  r_shadow;
    logic [c_IDX_W-1:0] r_index;
    logic               w_last;
    logic               w_advance;

    assign w_last    = (r_index == c_LAST_IDX);
    // A tx_done outside the wait phase belongs to no request of ours.
    assign w_advance = i_wait && i_tx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_index  <= '0;
        end else if (i_start) begin
            // Cast zero-extends the bus into the byte-padded shadow.
            r_shadow <= c_SH_W'(i_dbg_data);
            r_index  <= '0;
        end else if (w_advance) begin
            r_index <= w_last ? '0 : r_index + c_IDX_W'(1);
        end
    end

    // Selected byte only moves on an acknowledged transfer, so it stays
    // stable from the start request until the matching tx_done.
    assign o_data_send = r_shadow[{r_index, 3'b000} +: 8];
    assign o_tx_start  = i_send;
    assign o_done_all  = w_advance && w_last;

endmodule
`default_nettype wire

// File: rtl/mips_debug_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_debug_unit
// Purpose  : UART-side debug controller for the MIPS core. Decodes command
//            bytes, loads program memory with count-framed words, runs or
//            single-steps the core and streams a debug-bus snapshot back.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_rx_done/i_data- received byte strobe and value
//            i_tx_done       - transmitter finished the current byte
//            i_stop          - core has halted (level)
//            i_dbg_data      - core state bus
//            o_step          - core clock enable
//            o_mem_write     - program memory write strobe
//            o_instruction   - program memory write data
//            o_address       - program memory write address
//            o_data_send     - byte to transmit
//            o_tx_start      - transmit request
//            o_busy          - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module mips_debug_unit
    import mips_debug_pkg::*;
#(
    parameter int DBG_W       = 2558,
    parameter int INSTR_BYTES = 4,
    parameter int ADDR_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rx_done,
    input  logic [7:0]               i_data,
    input  logic                     i_tx_done,
    input  logic                     i_stop,
    input  logic [DBG_W-1:0]         i_dbg_data,
    output logic                     o_step,
    output logic                     o_mem_write,
    output logic [8*INSTR_BYTES-1:0] o_instruction,
    output logic [ADDR_W-1:0]        o_address,
    output logic [7:0]               o_data_send,
    output logic                     o_tx_start,
    output logic                     o_busy
);

    localparam int c_INSTR_W = 8 * INSTR_BYTES;
    localparam int c_NBYTES  = nbytes(DBG_W);
    localparam int c_BC_W    = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(INSTR_BYTES - 1);

    dbg_state_t         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [c_INSTR_W-1:0] r_word;
    logic [7:0]         r_count;
    logic [c_BC_W-1:0]  r_byte_cnt;
    logic               w_done_all;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_word     <= '0;
            r_count    <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        case (i_data)
                            c_CMD_LOAD: begin
                                r_state <= ST_LOAD_CNT;
                                r_addr  <= '0;
                            end
                            c_CMD_RUN:  r_state <= ST_RUN;
                            c_CMD_STEP: r_state <= ST_STEP;
                            c_CMD_DUMP: r_state <= ST_SNAP;
                            default:    r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD_CNT: begin
                    if (i_rx_done) begin
                        if (i_data == 8'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_count    <= i_data;
                            r_byte_cnt <= '0;
                            r_state    <= ST_LOAD_BYTE;
                        end
                    end
                end
                ST_LOAD_BYTE: begin
                    if (i_rx_done) begin
                        // MSB first: each new byte shifts in at the bottom.
                        r_word <= (r_word << 8) | c_INSTR_W'(i_data);
                        if (r_byte_cnt == c_BC_LAST) begin
                            r_byte_cnt <= '0;
                            r_state    <= ST_LOAD_WR;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BC_W'(1);
                        end
                    end
                end
                ST_LOAD_WR: begin
                    // Write strobe is this cycle; bump address afterwards.
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_count <= r_count - 8'd1;
                    r_state <= (r_count == 8'd1) ? ST_IDLE : ST_LOAD_BYTE;
                end
                ST_RUN: begin
                    if (i_stop) r_state <= ST_SNAP;
                end
                ST_STEP:    r_state <= ST_SNAP;
                ST_SNAP:    r_state <= ST_TX_SEND;
                ST_TX_SEND: r_state <= ST_TX_WAIT;
                ST_TX_WAIT: begin
                    if (w_done_all)     r_state <= ST_IDLE;
                    else if (i_tx_done) r_state <= ST_TX_SEND;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The step enable reacts to i_stop in the same cycle so the core never
    // gets an extra clock after it reports the halt.
    assign o_step        = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !i_stop;
    assign o_mem_write   = (r_state == ST_LOAD_WR);
    assign o_address     = r_addr;
    assign o_instruction = r_word;
    assign o_busy        = (r_state != ST_IDLE);

    dbg_byte_serializer #(
        .DBG_W  (DBG_W),
        .NBYTES (c_NBYTES)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .i_start     (r_state == ST_SNAP),
        .i_send      (r_state == ST_TX_SEND),
        .i_wait      (r_state == ST_TX_WAIT),
        .i_tx_done   (i_tx_done),
        .i_dbg_data  (i_dbg_data),
        .o_data_send (o_data_send),
        .o_tx_start  (o_tx_start),
        .o_done_all  (w_done_all)
    );

endmodule
`default_nettype wire
